mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
// - Iterative signed multiply/divide engine for the datapath ALU. Produces the 64-bit
//   result that the HI/LO result register pair (two 32-bit enable/clear registers) captures.
// - Sits between the bus operand registers (A from Y, B from bus) and the HI/LO registers.
// - done drives the HI/LO register enables; z_hi/z_lo drive their data inputs.
// PARAMETERS
// - WIDTH  32  operand width; result is 2*WIDTH split into z_hi/z_lo.
// PORTS
// - clock         in   1      single system clock, rising-edge
// - clear         in   1      asynchronous active-low reset
// - start         in   1      request; sampled only in IDLE
// - op            in   1      0 = MUL, 1 = DIV; latched with start
// - a             in   WIDTH  multiplicand / dividend (signed); latched with start
// - b             in   WIDTH  multiplier / divisor (signed); latched with start
// - busy          out  1      high from cycle after start accepted until done cycle inclusive
// - done          out  1      one-cycle pulse; z_hi/z_lo valid in the same cycle
// - z_hi          out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
// - z_lo          out  WIDTH  MUL: product[W-1:0];  DIV: quotient
// - div_by_zero   out  1      valid with done; high only for DIV with b == 0
// BEHAVIOUR
// - Reset (clear = 0, any time, async): state = IDLE; busy, done, div_by_zero = 0;
//   z_hi, z_lo = 0; internal operands/counters zero. Reset mid-operation aborts; no done.
// - FSM: IDLE -> MUL | DIV on start; MUL -> DONE after WIDTH iterations;
//   DIV -> FIX after WIDTH iterations; FIX -> DONE; DONE -> IDLE unconditionally.
// - start while busy or in DONE: ignored, no queuing. start in IDLE with op sampled at edge k.
// - Latency (start sampled at edge k): MUL done high after edge k+WIDTH+1;
//   DIV done high after edge k+WIDTH+2. Fixed, independent of operand values.
// - MUL: radix-2 Booth, one step/cycle, 2W+1-bit accumulator, arithmetic shift right.
//   Full signed 2W-bit product, no overflow possible.
// - DIV: restoring division on magnitudes, one quotient bit/cycle; FIX cycle applies signs.
//   Quotient truncates toward zero; remainder takes sign of dividend; |rem| < |b|.
// - b == 0: iterations still run (fixed latency); result forced to z_lo = all ones,
//   z_hi = a; div_by_zero = 1 with done.
// - a = most-negative, b = -1: z_lo = most-negative (wraps), z_hi = 0; no flag.
// - Magnitude of most-negative handled as unsigned W-bit value (no overflow in core).
// - z_hi/z_lo/div_by_zero update only in the DONE-entry cycle and hold until the next
//   operation's done; never glitch mid-operation.
// - done and busy both high in the DONE cycle; busy low in IDLE.
// STRUCTURE
// - Shared package: OP_MUL/OP_DIV constants, FSM state encoding (IDLE, MUL, DIV, FIX,
//   DONE), default WIDTH.
// - One natural sub-module: div_step (combinational restoring-division step: partial
//   remainder, divisor magnitude -> next remainder, quotient bit). Booth step stays inline.
// - Iteration counter $clog2(WIDTH)+1 bits; all state registers on posedge clock / negedge clear.
// TESTING
// - MUL a=7, b=-3 -> after 33 edges: done=1, z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB.
// - MUL a=b=0x80000000 -> z_hi=0x40000000, z_lo=0x00000000, done on edge 33.
// - DIV a=-17, b=5 -> on edge 34: z_lo=0xFFFFFFFD (-3), z_hi=0xFFFFFFFE (-2), flag=0.
// - DIV a=10, b=0 -> z_lo=0xFFFFFFFF, z_hi=0x0000000A, div_by_zero=1; DIV 0x80000000/-1
//   -> z_lo=0x80000000, z_hi=0.
// - start re-asserted during busy -> ignored; result and done timing of first op unchanged.
// - clear pulsed low at edge 10 of a MUL -> busy=0, z_hi=z_lo=0, no done; subsequent
//   MUL 6*7 -> z_lo=0x0000002A, z_hi=0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide engine:
// op codes, FSM state encoding and default operand width.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step on magnitudes.
// rem_i/bit_i/dsr_i in; rem_o (next remainder) and q_o (quotient bit) out.
module mul_div_unit_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] trial;

  // rem_i < dsr_i, so the shifted value fits in WIDTH+1 bits and
  // the trial sign bit alone decides whether to restore.
  assign shf   = {rem_i, bit_i};
  assign trial = shf - {1'b0, dsr_i};
  assign q_o   = ~trial[WIDTH];
  assign rem_o = q_o ? trial[WIDTH-1:0] : shf[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed MUL (radix-2 Booth) / DIV (restoring) engine.
// clock/clear(async low), start/op/a/b in; busy/done/z_hi/z_lo/div_by_zero out.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             sa_q;
  logic             sq_q;
  logic             bz_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] zhi_q;
  logic [WIDTH-1:0] zlo_q;
  logic             dbz_q;

  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   m_x;
  logic [WIDTH:0]   sum_d;
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // acc = {hi[W], lo[W], q-1}. The add is done one bit wider so a
  // most-negative multiplicand cannot overflow before the shift.
  always_comb begin
    hi_x  = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
    m_x   = {m_q[WIDTH-1], m_q};
    sum_d = hi_x;
    unique case (acc_q[1:0])
      2'b01:   sum_d = hi_x + m_x;
      2'b10:   sum_d = hi_x - m_x;
      default: sum_d = hi_x;
    endcase
    acc_d = {sum_d, acc_q[WIDTH:1]};
  end

  // Magnitude of the most-negative value is its own unsigned pattern.
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    q_fix = sq_q ? -dvd_q : dvd_q;
    r_fix = sa_q ? -rem_q : rem_q;
  end

  mul_div_unit_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dsr_i (dsr_q),
    .rem_o (rem_d),
    .q_o   (qbit_d)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sq_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            m_q    <= a;
            cnt_q  <= '0;
            if (op == OP_DIV) begin
              state_q <= S_DIV;
              dvd_q   <= a_mag;
              dsr_q   <= b_mag;
              rem_q   <= '0;
              sa_q    <= a[WIDTH-1];
              sq_q    <= a[WIDTH-1] ^ b[WIDTH-1];
              bz_q    <= (b == '0);
            end else begin
              state_q <= S_MUL;
              acc_q   <= {{WIDTH{1'b0}}, b, 1'b0};
            end
          end
        end
        S_MUL: begin
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            zhi_q   <= acc_q[AW-1:WIDTH+1];
            zlo_q   <= acc_q[WIDTH:1];
            dbz_q   <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end else begin
            rem_q <= rem_d;
            dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          dbz_q   <= bz_q;
          if (bz_q) begin
            zhi_q <= m_q;
            zlo_q <= '1;
          end else begin
            zhi_q <= r_fix;
            zlo_q <= q_fix;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign z_hi        = zhi_q;
  assign z_lo        = zlo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed MUL/DIV vectors,
// latency, busy/done, ignored start, and async clear abort.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] z_hi;
  logic [W-1:0] z_lo;
  logic         div_by_zero;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .z_hi        (z_hi),
    .z_lo        (z_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           at;
    string        nm;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clock) begin
    if (clear && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_hi"}, 64'(z_hi), 64'(e.hi));
        chk({e.nm, "_lo"}, 64'(z_lo), 64'(e.lo));
        chk({e.nm, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        chk({e.nm, "_cycle"}, 64'(cyc), 64'(e.at));
        chk({e.nm, "_busy_at_done"}, 64'(busy), 64'd1);
      end
    end
  end

  task automatic issue(string nm, logic o, logic [W-1:0] x, logic [W-1:0] y,
                       logic [W-1:0] eh, logic [W-1:0] el, logic ed, bit push);
    exp_t t;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) begin
      t.hi  = eh;
      t.lo  = el;
      t.dbz = ed;
      t.at  = cyc + 1 + W + 1 + (o ? 1 : 0);
      t.nm  = nm;
      sbq.push_back(t);
    end
    @(negedge clock);
    start = 1'b0;
    op    = ~o;
    a     = $urandom;
    b     = $urandom;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_done_low"}, 64'(done), 64'd0);
  endtask

  task automatic run(string nm, logic o, logic [W-1:0] x, logic [W-1:0] y,
                     logic [W-1:0] eh, logic [W-1:0] el, logic ed);
    issue(nm, o, x, y, eh, el, ed, 1'b1);
    wait_idle(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_z", {z_hi, z_lo}, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    clear = 1'b1;

    run("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run("mul_min_min", OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
    run("mul_m1_m1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    run("mul_max_max", OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);
    run("mul_min_max", OP_MUL, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0);
    repeat (3) @(negedge clock);
    chk("hold_z", {z_hi, z_lo}, 64'hC0000000_80000000);

    run("div_m17_5", OP_DIV, 32'hFFFFFFEF, 32'd5, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    run("div_10_0", OP_DIV, 32'd10, 32'd0, 32'h0000000A, 32'hFFFFFFFF, 1'b1);
    run("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
    run("div_m7_m2", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3, 1'b0);
    run("div_5_m7", OP_DIV, 32'd5, 32'hFFFFFFF9, 32'h5, 32'h0, 1'b0);
    run("div_m1_0", OP_DIV, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    run("div_max_16", OP_DIV, 32'h7FFFFFFF, 32'd16, 32'hF, 32'h07FFFFFF, 1'b0);

    issue("mul_3_5", OP_MUL, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clock);
    start = 1'b0;
    wait_idle("mul_3_5");

    issue("abort", OP_MUL, 32'd100, 32'd200, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (8) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_z", {z_hi, z_lo}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_no_done", 64'(done), 64'd0);

    run("mul_6_7", OP_MUL, 32'd6, 32'd7, 32'h0, 32'h0000002A, 1'b0);

    repeat (5) @(negedge clock);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
